// File: rtl/snail_pkg.sv
// snail_pkg: shared types and defaults for the snail front end.
// The serializer state encoding is shared here so that other blocks and
// benches can refer to it by name.
package snail_pkg;

   // Default word width of the parallel input.
   localparam int SNAIL_DATA_W_DEF = 8;

   // Serializer control states. SER_PAR is only reachable when the
   // parity option is compiled in.
   typedef enum logic [1:0] {
      SER_IDLE  = 2'd0,
      SER_SHIFT = 2'd1,
      SER_PAR   = 2'd2
   } ser_state_t;

endpackage : snail_pkg

// File: rtl/snail_serializer.sv
// snail_serializer: parallel-to-serial front end for the snail detector.
// Takes DATA_W-bit words on a valid/ready handshake and shifts them out
// MSB-first on A, one bit per clock. A is held at 0 whenever no word is
// in flight so idle gaps never look like part of a pattern.
// Optional build macro: SNAIL_SER_PARITY_EN appends one even-parity bit
// after each word (word period DATA_W+1 instead of DATA_W).
module snail_serializer
   import snail_pkg::*;
#(
   parameter int DATA_W = SNAIL_DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              A,
   output logic              a_valid,
   output logic              last,
   output logic              busy
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   // Counter value while the final data bit is on A.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   // Counter value one cycle before the final data bit.
   localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(DATA_W - 2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   ser_state_t        r_state;
   logic [DATA_W-1:0] r_shift;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_a;
   logic              r_a_valid;
   logic              r_last;
   logic              r_busy;
`ifdef SNAIL_SER_PARITY_EN
   logic              r_par;
`endif

   logic              w_cnt_last;
   logic              w_ready;
   logic              w_accept;

   assign w_cnt_last = (r_cnt == CNT_LAST);
   assign w_accept   = din_valid && w_ready;

   assign din_ready  = w_ready;
   assign A          = r_a;
   assign a_valid    = r_a_valid;
   assign last       = r_last;
   assign busy       = r_busy;

   // Ready for a new word when idle or on the final cycle of the current word.
   always_comb begin
      w_ready = 1'b0;
      case (r_state)
         SER_IDLE:  w_ready = 1'b1;
`ifdef SNAIL_SER_PARITY_EN
         SER_PAR:   w_ready = 1'b1;
`else
         SER_SHIFT: w_ready = w_cnt_last;
`endif
         default:   w_ready = 1'b0;
      endcase
   end

   // Control FSM, shift register, bit counter and registered serial outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= SER_IDLE;
         r_shift   <= '0;
         r_cnt     <= '0;
         r_a       <= 1'b0;
         r_a_valid <= 1'b0;
         r_last    <= 1'b0;
         r_busy    <= 1'b0;
`ifdef SNAIL_SER_PARITY_EN
         r_par     <= 1'b0;
`endif
      end else begin
         case (r_state)
            SER_IDLE: begin
               if (w_accept) begin
                  // MSB goes straight onto A; the rest waits in the shifter.
                  r_state   <= SER_SHIFT;
                  r_a       <= din[DATA_W-1];
                  r_shift   <= {din[DATA_W-2:0], 1'b0};
                  r_cnt     <= '0;
                  r_a_valid <= 1'b1;
                  r_last    <= 1'b0;
                  r_busy    <= 1'b1;
`ifdef SNAIL_SER_PARITY_EN
                  r_par     <= ^din;
`endif
               end else begin
                  r_a       <= 1'b0;
                  r_a_valid <= 1'b0;
                  r_last    <= 1'b0;
                  r_busy    <= 1'b0;
                  r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
               end
            end

            SER_SHIFT: begin
               if (!w_cnt_last) begin
                  r_a       <= r_shift[DATA_W-1];
                  r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
                  r_cnt     <= r_cnt + CNT_ONE;
                  r_a_valid <= 1'b1;
                  r_busy    <= 1'b1;
`ifdef SNAIL_SER_PARITY_EN
                  // The parity bit, not din[0], closes the word.
                  r_last    <= 1'b0;
`else
                  r_last    <= (r_cnt == CNT_PEN);
`endif
               end else begin
`ifdef SNAIL_SER_PARITY_EN
                  r_state   <= SER_PAR;
                  r_a       <= r_par;
                  r_a_valid <= 1'b1;
                  r_last    <= 1'b1;
                  r_busy    <= 1'b1;
                  r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
`else
                  if (w_accept) begin
                     // Back-to-back word: no bubble between words.
                     r_state   <= SER_SHIFT;
                     r_a       <= din[DATA_W-1];
                     r_shift   <= {din[DATA_W-2:0], 1'b0};
                     r_cnt     <= '0;
                     r_a_valid <= 1'b1;
                     r_last    <= 1'b0;
                     r_busy    <= 1'b1;
                  end else begin
                     r_state   <= SER_IDLE;
                     r_a       <= 1'b0;
                     r_a_valid <= 1'b0;
                     r_last    <= 1'b0;
                     r_busy    <= 1'b0;
                     r_cnt     <= '0;
                     r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
                  end
`endif
               end
            end

`ifdef SNAIL_SER_PARITY_EN
            SER_PAR: begin
               if (w_accept) begin
                  r_state   <= SER_SHIFT;
                  r_a       <= din[DATA_W-1];
                  r_shift   <= {din[DATA_W-2:0], 1'b0};
                  r_cnt     <= '0;
                  r_a_valid <= 1'b1;
                  r_last    <= 1'b0;
                  r_busy    <= 1'b1;
                  r_par     <= ^din;
               end else begin
                  r_state   <= SER_IDLE;
                  r_a       <= 1'b0;
                  r_a_valid <= 1'b0;
                  r_last    <= 1'b0;
                  r_busy    <= 1'b0;
                  r_cnt     <= '0;
                  r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
               end
            end
`endif

            default: begin
               // Unreachable encoding: fall back to the reset condition.
               r_state   <= SER_IDLE;
               r_shift   <= '0;
               r_cnt     <= '0;
               r_a       <= 1'b0;
               r_a_valid <= 1'b0;
               r_last    <= 1'b0;
               r_busy    <= 1'b0;
`ifdef SNAIL_SER_PARITY_EN
               r_par     <= 1'b0;
`endif
            end
         endcase
      end
   end

endmodule : snail_serializer

// File: tb/tb_snail_serializer.sv
// tb_snail_serializer: self-checking bench for snail_serializer (DATA_W=8).
// A queue of expected serial bits is filled from each observed handshake
// and drained one entry per clock; the bench also keeps a 1101/1110
// window counter standing in for the downstream detector.
`timescale 1ns/1ps
module tb_snail_serializer;

   localparam int DW = 8;
`ifdef SNAIL_SER_PARITY_EN
   localparam int P = DW + 1;
`else
   localparam int P = DW;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] din;
   logic          din_valid;
   logic          din_ready;
   logic          A;
   logic          a_valid;
   logic          last;
   logic          busy;

   snail_serializer #(.DATA_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .A         (A),
      .a_valid   (a_valid),
      .last      (last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic b;
      logic l;
   } sbit_t;

   typedef struct {
      logic [DW-1:0] din;
      logic [DW-1:0] exp_bits;
      logic          exp_par;
   } vec_t;

   sbit_t      q[$];
   sbit_t      cur;
   logic       cur_v;
   bit         hs_g;
   int         n_chk = 0;
   int         n_bad = 0;
   int         det_cnt = 0;
   logic [3:0] hist = 4'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: a word becomes DW bits MSB-first, plus parity when enabled.
   task automatic push_word(input logic [DW-1:0] w);
      sbit_t s;
      for (int i = DW - 1; i >= 0; i--) begin
         s.b = w[i];
`ifdef SNAIL_SER_PARITY_EN
         s.l = 1'b0;
`else
         s.l = (i == 0);
`endif
         q.push_back(s);
      end
`ifdef SNAIL_SER_PARITY_EN
      s.b = ^w;
      s.l = 1'b1;
      q.push_back(s);
`endif
   endtask

   // One clock: observe handshake, advance model, check all outputs.
   task automatic cyc();
      hs_g = rst && din_valid && din_ready;
      @(posedge clk);
      if (hs_g) push_word(din);
      if (!rst) q.delete();
      if (q.size() > 0) begin
         cur   = q.pop_front();
         cur_v = 1'b1;
      end else begin
         cur.b = 1'b0;
         cur.l = 1'b0;
         cur_v = 1'b0;
      end
      #1;
      chk("A", A, cur.b);
      chk("a_valid", a_valid, cur_v);
      chk("last", last, cur.l);
      chk("busy", busy, cur_v);
      chk("din_ready", din_ready, (q.size() == 0));
      hist = {hist[2:0], A};
      if (hist == 4'b1101 || hist == 4'b1110) det_cnt++;
   endtask

   task automatic send(input logic [DW-1:0] w);
      din       = w;
      din_valid = 1'b1;
      for (int t = 0; t < 40; t++) begin
         cyc();
         if (hs_g) break;
      end
      chk("accept_timeout", hs_g, 1);
      din_valid = 1'b0;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[9];
      logic [31:0] got;
      int          rdy_cnt;
      int          vld_cnt;
      int          wt;

      tbl[0] = '{8'hD0, 8'b1101_0000, 1'b1};
      tbl[1] = '{8'hC0, 8'b1100_0000, 1'b0};
      tbl[2] = '{8'hFF, 8'b1111_1111, 1'b0};
      tbl[3] = '{8'h00, 8'b0000_0000, 1'b0};
      tbl[4] = '{8'h01, 8'b0000_0001, 1'b1};
      tbl[5] = '{8'h80, 8'b1000_0000, 1'b1};
      tbl[6] = '{8'hA5, 8'b1010_0101, 1'b0};
      tbl[7] = '{8'h7E, 8'b0111_1110, 1'b0};
      tbl[8] = '{8'h3B, 8'b0011_1011, 1'b1};

      // Reset state
      rst = 1'b0; din_valid = 1'b0; din = '0;
      #2;
      chk("rst_A", A, 0);
      chk("rst_a_valid", a_valid, 0);
      chk("rst_last", last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", din_ready, 1);
      cyc(); cyc();
      rst = 1'b1;

      // Idle: nothing on A, detector quiet
      det_cnt = 0;
      for (int i = 0; i < 20; i++) cyc();
      chk("idle_det", det_cnt, 0);

      // Single D0 word: one 1101 window
      hist = 4'b0; det_cnt = 0;
      send(8'hD0);
      for (int i = 0; i < P + 3; i++) cyc();
      chk("det_D0", det_cnt, 1);

      // Table of single words
      for (int k = 0; k < 9; k++) begin
         send(tbl[k].din);
         din = DW'($urandom);
         got = '0;
         for (int i = 0; i < DW; i++) begin
            if (i > 0) cyc();
            got = {got[30:0], A};
         end
         chk("tbl_bits", got, {24'b0, tbl[k].exp_bits});
`ifdef SNAIL_SER_PARITY_EN
         cyc();
         chk("tbl_par", A, tbl[k].exp_par);
         chk("tbl_par_last", last, 1);
`endif
         cyc(); cyc();
      end

      // Back-to-back EE then 0F with din_valid held high
      send(8'hEE);
      din = 8'h0F; din_valid = 1'b1;
      got = '0; rdy_cnt = 0; vld_cnt = 0;
      for (int i = 0; i < 2 * P; i++) begin
         if (i > 0) cyc();
         if (hs_g && i > 0) din_valid = 1'b0;
         got = {got[30:0], A};
         vld_cnt += a_valid;
         if (din_ready && i < 2 * P - 1) rdy_cnt++;
         if (i == P - 1) chk("b2b_ready_last", din_ready, 1);
      end
      din_valid = 1'b0;
`ifdef SNAIL_SER_PARITY_EN
      chk("b2b_stream", got, {14'b0, 8'hEE, 1'b0, 8'h0F, 1'b0});
`else
      chk("b2b_stream", got, {16'b0, 8'hEE, 8'h0F});
`endif
      chk("b2b_contig", vld_cnt, 2 * P);
      chk("b2b_ready_cnt", rdy_cnt, 1);
      for (int i = 0; i < 3; i++) cyc();

      // Backpressure: din_valid raised at bit index 2
      send(8'h5A);
      cyc(); cyc();
      din = 8'h96; din_valid = 1'b1;
      wt = 0;
      for (int t = 0; t < 40; t++) begin
         cyc();
         wt++;
         if (hs_g) break;
      end
      din_valid = 1'b0;
      chk("bp_wait", wt, P - 2);
      chk("bp_msb", A, 1);
      chk("bp_nogap", a_valid, 1);
      for (int i = 0; i < P + 2; i++) cyc();

      // Asynchronous reset in the middle of FF
      send(8'hFF);
      cyc(); cyc(); cyc();
      #3;
      rst = 1'b0;
      #1;
      q.delete();
      chk("mid_rst_A", A, 0);
      chk("mid_rst_valid", a_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", din_ready, 1);
      cyc();
      rst = 1'b1;
      vld_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         vld_cnt += a_valid;
      end
      chk("post_rst_residual", vld_cnt, 0);

      // Randomized traffic against the queue model
      for (int i = 0; i < 600; i++) begin
         cyc();
         if (hs_g) din_valid = 1'b0;
         if (!din_valid && $urandom_range(0, 3) != 0) begin
            din       = DW'($urandom);
            din_valid = 1'b1;
         end
      end
      din_valid = 1'b0;
      for (int i = 0; i < 2 * P + 2; i++) cyc();
      chk("drain", q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule : tb_snail_serializer
